// File: rtl/sram_pkg.sv
// Shared types and defaults for the clocked SRAM controller.
// Optional SRAM_BYTE_EN adds per-lane write enables.
package sram_pkg;

  localparam int SRAM_ADDR_W      = 19;
  localparam int SRAM_DATA_W      = 16;
  localparam int SRAM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  function automatic int cnt_w(input int wc);
    int w;
    w = $clog2(wc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/ready/ack bus of the SRAM controller.
// The be lanes exist only when SRAM_BYTE_EN is defined.
interface sram_ctrl_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) ();

  logic              req;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef SRAM_BYTE_EN
  logic [DATA_W/8-1:0] be;
`endif
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
`ifdef SRAM_BYTE_EN
    output be,
`endif
    output req, we, addr, wdata,
    input  ready, ack, rdata
  );

  modport slave (
`ifdef SRAM_BYTE_EN
    input  be,
`endif
    input  req, we, addr, wdata,
    output ready, ack, rdata
  );

endinterface

// File: rtl/sram_io.sv
// Data-pin tristate driver and registered read capture.
// Drive enable and write data are flops so the pins never see CPU inputs.
module sram_io #(
  parameter int DATA_W = 16
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              drive_d,
  input  logic              dout_ld,
  input  logic [DATA_W-1:0] dout_in,
  input  logic              cap_en,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [DATA_W-1:0] rdata
);

  logic              drive_q;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    dout_d  = dout_q;
    rdata_d = rdata_q;
    if (dout_ld) dout_d = dout_in;
    if (cap_en) rdata_d = sram_data;
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      drive_q <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      drive_q <= drive_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_data = drive_q ? dout_q : 'z;
  assign rdata     = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// Clocked async-SRAM sequencer: SETUP, WAIT_CYCLES+1 ACCESS, HOLD.
// Define SRAM_BYTE_EN to enable per-lane write masking via bus.be.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic                sck,
  input  logic                rst,
  sram_ctrl_if.slave          bus,
  output logic [ADDR_W-1:0]   sram_addr,
  inout  wire  [DATA_W-1:0]   sram_data,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  localparam int LANES = DATA_W / 8;
  localparam int CW    = cnt_w(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [LANES-1:0]  be_n_q, be_n_d;
  logic              ack_q, ack_d;
  logic              drive_d;
  logic              accept;
  logic              cap_en;
  logic [LANES-1:0]  be_in;

`ifdef SRAM_BYTE_EN
  assign be_in = bus.be;
`else
  assign be_in = '1;
`endif

  assign bus.ready = (state_q == IDLE) && !rst;
  assign accept    = bus.req && bus.ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          we_d    = bus.we;
          addr_d  = bus.addr;
          be_d    = bus.we ? be_in : '1;
          cnt_d   = CNT_LOAD;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (cnt_q == '0) state_d = HOLD;
        else cnt_d = cnt_q - 1'b1;
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they land registered.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    drive_d = 1'b0;
    ack_d   = 1'b0;
    unique case (state_d)
      SETUP: begin
        ce_n_d  = 1'b0;
        oe_n_d  = we_d;
        be_n_d  = ~be_d;
        drive_d = we_d;
      end
      ACCESS: begin
        ce_n_d  = 1'b0;
        oe_n_d  = we_d;
        we_n_d  = !(we_d && |be_d);
        be_n_d  = ~be_d;
        drive_d = we_d;
      end
      HOLD: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~be_d;
        drive_d = we_d;
        ack_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cap_en = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      ack_q   <= ack_d;
    end
  end

  sram_io #(
    .DATA_W (DATA_W)
  ) u_io (
    .sck       (sck),
    .rst       (rst),
    .drive_d   (drive_d),
    .dout_ld   (accept),
    .dout_in   (bus.wdata),
    .cap_en    (cap_en),
    .sram_data (sram_data),
    .rdata     (bus.rdata)
  );

  assign bus.ack   = ack_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: WAIT_CYCLES=2 unit with SRAM model, WAIT_CYCLES=0 unit.
// Byte-lane steps run only when SRAM_BYTE_EN is defined.
module tb_sram_ctrl;
  import sram_pkg::*;

  logic sck = 1'b0;
  logic rst = 1'b1;
  always #5 sck = ~sck;

  sram_ctrl_if #(.ADDR_W(19), .DATA_W(16)) b0 ();
  sram_ctrl_if #(.ADDR_W(19), .DATA_W(16)) b1 ();

  wire  [15:0] d0, d1;
  logic [18:0] a0, a1;
  logic        ce0, oe0, we0, ce1, oe1, we1;
  logic [1:0]  bn0, bn1;

  sram_ctrl #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(2)) u0 (
    .sck(sck), .rst(rst), .bus(b0),
    .sram_addr(a0), .sram_data(d0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0),
    .sram_be_n(bn0)
  );

  sram_ctrl #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(0)) u1 (
    .sck(sck), .rst(rst), .bus(b1),
    .sram_addr(a1), .sram_data(d1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
    .sram_be_n(bn1)
  );

  // Async SRAM model behind u0
  logic [15:0] mem [256];
  always @(posedge sck) begin
    if (!ce0 && !we0) begin
      if (!bn0[0]) mem[a0[7:0]][7:0]  <= d0[7:0];
      if (!bn0[1]) mem[a0[7:0]][15:8] <= d0[15:8];
    end
  end
  assign d0 = (!ce0 && !oe0 && we0) ? mem[a0[7:0]] : 16'hzzzz;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // One u0 access from accept edge to first IDLE cycle (cycles 1..6)
  task automatic seq0(input string nm, input bit w, input bit lanes,
                      input logic [15:0] exp_rd, input logic [1:0] exp_bn,
                      input logic [18:0] exp_a);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) b0.req = 1'b0;
      chk({nm, "_ce"}, ce0, c == 6);
      chk({nm, "_we"}, we0, !(w && lanes && c >= 2 && c <= 4));
      chk({nm, "_oe"}, oe0, !(!w && c <= 4));
      chk({nm, "_drv"}, u0.u_io.drive_q, w && c <= 5);
      chk({nm, "_ack"}, b0.ack, c == 5);
      chk({nm, "_rdy"}, b0.ready, c == 6);
      if (c == 2) chk({nm, "_ben"}, bn0, exp_bn);
      if (c == 1 || c == 6) chk({nm, "_addr"}, a0, exp_a);
      if (!w && c >= 5) chk({nm, "_rdata"}, b0.rdata, exp_rd);
    end
  endtask

  initial begin
    int n_ack;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0;
    b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
`ifdef SRAM_BYTE_EN
    b0.be = 2'b11;
    b1.be = 2'b11;
`endif

    rst = 1'b1;
    tick();
    chk("rst_ready", b0.ready, 0);
    chk("rst_ack", b0.ack, 0);
    chk("rst_rdata", b0.rdata, 0);
    chk("rst_addr", a0, 0);
    chk("rst_ce", ce0, 1);
    chk("rst_oe", oe0, 1);
    chk("rst_we", we0, 1);
    chk("rst_ben", bn0, 2'b11);
    chk("rst_drv", u0.u_io.drive_q, 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_after", b0.ready, 1);

    b0.req = 1; b0.we = 1; b0.addr = 19'h1234; b0.wdata = 16'hBEEF;
    seq0("wr", 1, 1, 16'h0000, 2'b00, 19'h01234);

    b0.req = 1; b0.we = 0; b0.addr = 19'h1234; b0.wdata = 16'h0000;
    seq0("rd", 0, 1, 16'hBEEF, 2'b00, 19'h01234);

    // WAIT_CYCLES=0 with req held for three writes
    chk("w0_rdy0", b1.ready, 1);
    b1.req = 1; b1.we = 1; b1.addr = 19'h10; b1.wdata = 16'h1111;
    n_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("w0_ready", b1.ready, (c % 4) == 0);
      chk("w0_ack", b1.ack, (c % 4) == 3);
      chk("w0_ce", ce1, (c % 4) == 0);
      chk("w0_oe", oe1, 1);
      if (c % 4 == 2) chk("w0_we", we1, 0);
      if (b1.ack) n_ack++;
      if (c == 11) b1.req = 0;
    end
    chk("w0_nack", n_ack, 3);
    chk("w0_addr", a1, 19'h10);
    chk("w0_ben", bn1, 2'b11);

    // Reset during ACCESS of a write
    b0.req = 1; b0.we = 1; b0.addr = 19'h55; b0.wdata = 16'h7777;
    tick();
    b0.req = 0;
    tick();
    chk("ab_we_low", we0, 0);
    rst = 1'b1;
    tick();
    chk("ab_ce", ce0, 1);
    chk("ab_we", we0, 1);
    chk("ab_oe", oe0, 1);
    chk("ab_drv", u0.u_io.drive_q, 0);
    chk("ab_ack", b0.ack, 0);
    chk("ab_rdy_rst", b0.ready, 0);
    rst = 1'b0;
    #1;
    chk("ab_rdy", b0.ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ab_noack", b0.ack, 0);
    end

`ifdef SRAM_BYTE_EN
    b0.req = 1; b0.we = 1; b0.addr = 19'h0; b0.wdata = 16'hAA55;
    b0.be = 2'b10;
    seq0("be", 1, 1, 16'h0000, 2'b01, 19'h0);
    b0.req = 1; b0.we = 0; b0.addr = 19'h0; b0.be = 2'b00;
    seq0("rb", 0, 1, 16'hAA00, 2'b00, 19'h0);
    b0.req = 1; b0.we = 1; b0.addr = 19'h0; b0.wdata = 16'hFFFF;
    b0.be = 2'b00;
    seq0("bz", 1, 0, 16'h0000, 2'b11, 19'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised, clocked successor to the combinational SRAM port. Converts a single-outstanding request/ready/ack handshake from the CPU-side bus into correctly sequenced asynchronous SRAM cycles. Sequencing covers address setup, programmable wait states, write-data hold and bus turnaround, with registered strobes and registered read data. Sits between the memory-access stage and the board SRAM pins.

## Interface
- ADDR_W, 19, SRAM word-address width (1..32)
- DATA_W, 16, SRAM data width; multiple of 8, ≥8; lanes = DATA_W/8
- WAIT_CYCLES, 2, extra access cycles beyond one (0..15)
- sck  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- req  in  1  request valid
- ready  out  1  controller idle and able to accept
- we  in  1  0 = read, 1 = write
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  DATA_W/8  write lane enables (present only with SRAM_BYTE_EN)
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid at ack of a read, held until next read completes
- sram_addr  out  ADDR_W  SRAM address pins
- sram_data  inout  DATA_W  SRAM data pins
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  DATA_W/8  active-low lane strobes (lane 0 = LSB, matches lb/ub for 16 bits)

## Operation
- States: IDLE, SETUP, ACCESS, HOLD.
- ready = (state==IDLE) && !rst.
- Accept when req && ready at a rising edge: latch we, addr, wdata, be; go to SETUP.
- Inputs other than req are don't-care when not accepted.
- SETUP (1 cycle): sram_addr driven, ce_n=0, be_n per access.
  - Read: oe_n=0.
  - Write: data bus driven, we_n=1.
- ACCESS (WAIT_CYCLES+1 cycles, down-counter): strobes as in SETUP; for writes we_n=0.
  - Read data is captured into rdata at the edge ending the last ACCESS cycle.
- HOLD (1 cycle):
  - we_n=1, oe_n=1, ce_n=0, address held.
  - Write data still driven.
  - Read bus already released.
  - ack=1.
- HOLD then IDLE: all strobes high, bus hi-Z, address holds last value.
- Data bus is driven only during SETUP/ACCESS/HOLD of writes; hi-Z otherwise.
- Counter width: max(1, clog2(WAIT_CYCLES+1)); no wrap, reloaded on each SETUP entry.

## Timing
- Accept at edge 0; SETUP in cycle 1; ACCESS in cycles 2..WAIT_CYCLES+2; HOLD/ack in cycle WAIT_CYCLES+3; ready again in cycle WAIT_CYCLES+4.
- Latency accept→ack = WAIT_CYCLES+3; back-to-back throughput one access per WAIT_CYCLES+4 cycles.
- All pin outputs are registered; no combinational path from req/addr/wdata to SRAM pins.
- Reset values (applied at the first edge with rst=1):
  - state IDLE, ack=0, rdata=0, sram_addr=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n all 1, sram_data hi-Z.
- Reset mid-access aborts: strobes deassert and bus releases at that edge, and no ack is issued.
- req held high at ack: the next access is accepted only in the following IDLE cycle, never in HOLD.

## Configuration
- SRAM_BYTE_EN defined:
  - be port present.
  - Writes assert sram_be_n[i]=0 only for be[i]=1.
  - Write with be=0 runs the full sequence and acks, but we_n stays 1.
  - Reads enable all lanes.
- Not defined: be port absent; all lanes enabled on every access.

## Structure
- Package sram_pkg:
  - state enum typedef (IDLE, SETUP, ACCESS, HOLD).
  - default constants SRAM_ADDR_W=19, SRAM_DATA_W=16, SRAM_WAIT_CYCLES=2.
- One sub-module, sram_io: tristate driver for sram_data (drive enable + out data) plus the registered read-capture flop.

## Test plan
- Reset then write addr=0x1234, wdata=0xBEEF, WAIT_CYCLES=2 -> ack exactly 5 cycles after accept; we_n low cycles 2–4 only; bus driven cycles 1–5.
- Read back 0x1234 with SRAM model -> rdata=0xBEEF at ack; oe_n low cycles 1–4; bus hi-Z in HOLD.
- WAIT_CYCLES=0, req held high for 3 writes -> accepts spaced 4 cycles apart, 3 acks, ready low between.
- rst asserted in ACCESS of a write -> strobes high and bus hi-Z at the next edge; no ack; ready=1 after rst drops; the SRAM location is not relied upon.
- SRAM_BYTE_EN, write be=2'b10, wdata=0xAA55 over 0x0000 -> sram_be_n=2'b01; readback 0xAA00.
- SRAM_BYTE_EN, write be=0 -> ack after 5 cycles, we_n never low.
